// File: rtl/sipo_deser.sv
// sipo_deser: parametrised serial-in/parallel-out deserializer.
// Collects WIDTH serial bits (MSB-first or LSB-first, chosen per word on its
// first bit), presents each completed word on a registered output with a
// valid/ready handshake, and flags a sticky overrun when a completed word
// has to be dropped because the previous one is still unconsumed.
module sipo_deser #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_en,
    input  logic             msb_first,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] dout_n,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overrun
);

    logic [WIDTH-1:0] sr_q,    sr_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             mode_q,  mode_d;
    logic             valid_q, valid_d;
    logic             ovr_q,   ovr_d;

    logic             mode_eff;
    logic             last_bit;
    logic [WIDTH-1:0] shifted;

    // Shift datapath: the first bit of a word takes its mode straight from msb_first.
    always_comb begin
        mode_eff = (cnt_q == '0) ? msb_first : mode_q;
        shifted  = mode_eff ? {sr_q[WIDTH-2:0], din} : {din, sr_q[WIDTH-1:1]};
        last_bit = din_en && (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state: clear flush, handshake, bit accept and word completion.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (clear) begin
            sr_d    = '0;
            cnt_d   = '0;
            mode_d  = 1'b0;
            dout_d  = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            if (valid_q && dout_ready) begin
                valid_d = 1'b0;
            end
            if (din_en) begin
                if (cnt_q == '0) begin
                    mode_d = msb_first;
                end
                if (last_bit) begin
                    sr_d  = '0;
                    cnt_d = '0;
                    // A word completing in the same cycle as a handshake replaces
                    // the consumed one, so back-to-back words need no bubble.
                    if (!valid_q || dout_ready) begin
                        dout_d  = shifted;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    sr_d  = shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // Outputs are all derived from registered state.
    always_comb begin
        dout       = dout_q;
        dout_n     = ~dout_q;
        dout_valid = valid_q;
        busy       = (cnt_q != '0);
        overrun    = ovr_q;
    end

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: scoreboard-based bench for sipo_deser at WIDTH=8.
module tb_sipo_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         din;
    logic         din_en;
    logic         msb_first;
    logic         clear;
    logic [W-1:0] dout;
    logic [W-1:0] dout_n;
    logic         dout_valid;
    logic         dout_ready;
    logic         busy;
    logic         overrun;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_w;

    sipo_deser #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_en     (din_en),
        .msb_first  (msb_first),
        .clear      (clear),
        .dout       (dout),
        .dout_n     (dout_n),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Drive one accepted bit and settle just after the edge.
    task automatic clk_bit(input logic b);
        din    = b;
        din_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One idle edge with din_en low.
    task automatic idle;
        din_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_cmp++;
        if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_cmp++;
        if (dout_n !== 8'hFF) begin n_bad++; $display("FAIL reset_dout_n: got %h want ff", dout_n); end
        n_cmp++;
        if ({dout_valid, busy, overrun} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got v/b/o=%b want 000", {dout_valid, busy, overrun});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_msb_basic;
        logic [W-1:0] w;
        w = 8'hA5;
        msb_first  = 1'b1;
        dout_ready = 1'b1;
        sb.push_back(8'hA5);
        for (int i = 0; i < W; i++) begin
            clk_bit(w[W-1-i]);
            n_cmp++;
            if (busy !== (i != W - 1)) begin
                n_bad++; $display("FAIL basic_busy bit%0d: got %b want %b", i + 1, busy, (i != W - 1));
            end
        end
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL basic_sb: scoreboard empty"); end
        else begin
            exp_w = sb.pop_front();
            if (dout_valid !== 1'b1 || dout !== exp_w) begin
                n_bad++; $display("FAIL basic_word: got v=%b %h want v=1 %h", dout_valid, dout, exp_w);
            end
        end
        n_cmp++;
        if (dout_n !== 8'h5A) begin n_bad++; $display("FAIL basic_dout_n: got %h want 5a", dout_n); end
        idle();
        n_cmp++;
        if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL basic_pulse: got v=%b want 0", dout_valid); end
    endtask

    task automatic test_mode;
        logic [W-1:0] stream;
        stream = 8'b1000_0000;   // first bit sent is 1, rest 0
        for (int pass = 0; pass < 3; pass++) begin
            msb_first = (pass == 1);
            case (pass)
                0:       sb.push_back(8'h01);
                1:       sb.push_back(8'h80);
                default: sb.push_back(8'h01);
            endcase
            for (int i = 0; i < W; i++) begin
                if (pass == 2 && i == 3) msb_first = 1'b1;
                clk_bit(stream[W-1-i]);
            end
            n_cmp++;
            if (sb.size() == 0) begin n_bad++; $display("FAIL mode_sb pass%0d: scoreboard empty", pass); end
            else begin
                exp_w = sb.pop_front();
                if (dout_valid !== 1'b1 || dout !== exp_w) begin
                    n_bad++; $display("FAIL mode_word pass%0d: got v=%b %h want v=1 %h", pass, dout_valid, dout, exp_w);
                end
            end
            idle();
        end
    endtask

    task automatic test_gaps;
        logic [W-1:0] w;
        w = 8'h3C;
        msb_first = 1'b1;
        sb.push_back(8'h3C);
        for (int i = 0; i < W; i++) begin
            clk_bit(w[W-1-i]);
            if (i == 1 || i == 4) begin
                idle();
                idle();
                n_cmp++;
                if (busy !== 1'b1 || dout_valid !== 1'b0) begin
                    n_bad++; $display("FAIL gap_hold bit%0d: got b=%b v=%b want b=1 v=0", i + 1, busy, dout_valid);
                end
            end else if (i != W - 1) begin
                n_cmp++;
                if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL gap_early bit%0d: got v=%b want 0", i + 1, dout_valid); end
            end
        end
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL gap_sb: scoreboard empty"); end
        else begin
            exp_w = sb.pop_front();
            if (dout_valid !== 1'b1 || dout !== exp_w) begin
                n_bad++; $display("FAIL gap_word: got v=%b %h want v=1 %h", dout_valid, dout, exp_w);
            end
        end
        idle();
    endtask

    task automatic test_overrun;
        logic [W-1:0] w;
        msb_first  = 1'b1;
        dout_ready = 1'b0;
        w = 8'h11;
        sb.push_back(8'h11);
        for (int i = 0; i < W; i++) clk_bit(w[W-1-i]);
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL ovr_sb: scoreboard empty"); end
        else begin
            exp_w = sb.pop_front();
            if (dout_valid !== 1'b1 || dout !== exp_w || overrun !== 1'b0) begin
                n_bad++; $display("FAIL ovr_first: got v=%b %h o=%b want v=1 %h o=0", dout_valid, dout, overrun, exp_w);
            end
        end
        // Second word is dropped: nothing pushed to the scoreboard.
        w = 8'h22;
        for (int i = 0; i < W; i++) clk_bit(w[W-1-i]);
        n_cmp++;
        if (dout_valid !== 1'b1 || dout !== 8'h11 || overrun !== 1'b1) begin
            n_bad++; $display("FAIL ovr_drop: got v=%b %h o=%b want v=1 11 o=1", dout_valid, dout, overrun);
        end
        dout_ready = 1'b1;
        idle();
        dout_ready = 1'b0;
        n_cmp++;
        if (dout_valid !== 1'b0 || dout !== 8'h11 || overrun !== 1'b1) begin
            n_bad++; $display("FAIL ovr_consume: got v=%b %h o=%b want v=0 11 o=1", dout_valid, dout, overrun);
        end
        // Clear wins over a simultaneous accepted bit.
        clear = 1'b1;
        clk_bit(1'b1);
        clear  = 1'b0;
        din_en = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0 || dout !== 8'h00 || dout_n !== 8'hFF || busy !== 1'b0 || dout_valid !== 1'b0) begin
            n_bad++; $display("FAIL ovr_clear: got o=%b %h n=%h b=%b v=%b want o=0 00 n=ff b=0 v=0",
                              overrun, dout, dout_n, busy, dout_valid);
        end
        dout_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] s;
        s = 32'hDEADBEEF;
        msb_first  = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i % W == 0) sb.push_back(s[31-i -: 8]);
            clk_bit(s[31-i]);
            n_cmp++;
            if (i % W == W - 1) begin
                if (sb.size() == 0) begin n_bad++; $display("FAIL b2b_sb bit%0d: scoreboard empty", i); end
                else begin
                    exp_w = sb.pop_front();
                    if (dout_valid !== 1'b1 || dout !== exp_w) begin
                        n_bad++; $display("FAIL b2b_word bit%0d: got v=%b %h want v=1 %h", i, dout_valid, dout, exp_w);
                    end
                end
            end else if (dout_valid !== 1'b0) begin
                n_bad++; $display("FAIL b2b_gap bit%0d: got v=%b want 0", i, dout_valid);
            end
        end
        n_cmp++;
        if (overrun !== 1'b0) begin n_bad++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
        idle();
    endtask

    task automatic test_async_reset;
        logic [W-1:0] w;
        w = 8'hFF;
        msb_first = 1'b1;
        for (int i = 0; i < 5; i++) clk_bit(w[W-1-i]);
        din_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (dout !== 8'h00 || dout_n !== 8'hFF || {dout_valid, busy, overrun} !== 3'b000) begin
            n_bad++; $display("FAIL async_rst: got %h n=%h v/b/o=%b want 00 n=ff 000",
                              dout, dout_n, {dout_valid, busy, overrun});
        end
        #1;
        rst = 1'b0;
        w = 8'h5A;
        sb.push_back(8'h5A);
        for (int i = 0; i < W; i++) begin
            clk_bit(w[W-1-i]);
            if (i != W - 1) begin
                n_cmp++;
                if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL async_residue bit%0d: got v=%b want 0", i + 1, dout_valid); end
            end
        end
        n_cmp++;
        if (sb.size() == 0) begin n_bad++; $display("FAIL async_sb: scoreboard empty"); end
        else begin
            exp_w = sb.pop_front();
            if (dout_valid !== 1'b1 || dout !== exp_w) begin
                n_bad++; $display("FAIL async_word: got v=%b %h want v=1 %h", dout_valid, dout, exp_w);
            end
        end
        idle();
    endtask

    initial begin
        rst        = 1'b1;
        din        = 1'b0;
        din_en     = 1'b0;
        msb_first  = 1'b0;
        clear      = 1'b0;
        dout_ready = 1'b1;
        test_reset();
        test_msb_basic();
        test_mode();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
